// File: rtl/flo_fifo_if.sv
// Producer/consumer bundle for flo_fifo. The slave modport is the FIFO side.
// Error-flag signals exist only when FLOFIFO_ERR_FLAGS_EN is defined.
interface flo_fifo_if #(
  parameter int LENGTH = 32,
  parameter int WIDTH  = 32
);
  localparam int AW = $clog2(LENGTH);

  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             read_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic [AW-1:0]    locs_o;
  logic             empty_o;
  logic             full_o;
`ifdef FLOFIFO_ERR_FLAGS_EN
  logic             overflow_o;
  logic             underflow_o;
`endif

  modport master (
    output data_i, valid_i, read_i,
`ifdef FLOFIFO_ERR_FLAGS_EN
    input  overflow_o, underflow_o,
`endif
    input  data_o, valid_o, locs_o, empty_o, full_o
  );

  modport slave (
    input  data_i, valid_i, read_i,
`ifdef FLOFIFO_ERR_FLAGS_EN
    output overflow_o, underflow_o,
`endif
    output data_o, valid_o, locs_o, empty_o, full_o
  );
endinterface

// File: rtl/flo_fifo.sv
// Single-clock FIFO with registered pop output and count-derived status flags.
// Define FLOFIFO_ERR_FLAGS_EN to add sticky overflow_o/underflow_o flags.
module flo_fifo #(
  parameter int LENGTH = 32,
  parameter int WIDTH  = 32
) (
  input  logic       clk,
  input  logic       rst,
  flo_fifo_if.slave  bus
);
  localparam int AW = $clog2(LENGTH);

  logic [WIDTH-1:0] mem_q [LENGTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             empty, full, do_rd, do_wr;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(LENGTH));
  assign do_rd = bus.read_i && !empty;
  // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
  assign do_wr = bus.valid_i && (!full || bus.read_i);

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd)      count_d = count_q + (AW+1)'(1);
    else if (do_rd && !do_wr) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_wr && !rst) mem_q[wr_ptr_q] <= bus.data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= do_rd;
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) begin
        data_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.locs_o  = count_q[AW-1:0];
  assign bus.empty_o = empty;
  assign bus.full_o  = full;

`ifdef FLOFIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.valid_i && !do_wr) ovf_q <= 1'b1;
      if (bus.read_i && empty)   unf_q <= 1'b1;
    end
  end

  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
`endif
endmodule

// File: tb/tb_flo_fifo.sv
// Directed bench for flo_fifo: a reference count/queue model predicts every
// popped word and status flag, checked on the falling edge after each step.
module tb_flo_fifo;
  localparam int LEN = 32;
  localparam int W   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flo_fifo_if #(.LENGTH(LEN), .WIDTH(W)) bus ();
  flo_fifo #(.LENGTH(LEN), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          nchk = 0;
  int          nerr = 0;
  logic [W-1:0] sb_q[$];
  int          mcount = 0;
  logic [W-1:0] last_d = '0;
  bit          m_ovf = 0, m_unf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".locs_o"},  32'(bus.locs_o),  32'(mcount % LEN));
    chk({tag, ".empty_o"}, 32'(bus.empty_o), 32'(mcount == 0));
    chk({tag, ".full_o"},  32'(bus.full_o),  32'(mcount == LEN));
`ifdef FLOFIFO_ERR_FLAGS_EN
    chk({tag, ".overflow_o"},  32'(bus.overflow_o),  32'(m_ovf));
    chk({tag, ".underflow_o"}, 32'(bus.underflow_o), 32'(m_unf));
`endif
  endtask

  // Drive one cycle of stimulus from a falling edge, check at the next one.
  task automatic step(input string tag, input bit wr, input logic [W-1:0] d, input bit rd);
    bit exp_rd, exp_wr;
    bus.valid_i = wr;
    bus.data_i  = d;
    bus.read_i  = rd;
    exp_rd = rd && (mcount > 0);
    exp_wr = wr && ((mcount < LEN) || rd);
    if (wr && !exp_wr) m_ovf = 1;
    if (rd && mcount == 0) m_unf = 1;
    @(posedge clk);
    if (exp_wr) sb_q.push_back(d);
    if (exp_rd) last_d = sb_q.pop_front();
    mcount = mcount + int'(exp_wr) - int'(exp_rd);
    @(negedge clk);
    chk({tag, ".valid_o"}, 32'(bus.valid_o), 32'(exp_rd));
    chk({tag, ".data_o"},  bus.data_o, last_d);
    chk_status(tag);
    bus.valid_i = 1'b0;
    bus.read_i  = 1'b0;
  endtask

  // Reset with a write and read pending; both must be discarded.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'hDEAD;
    bus.read_i  = 1'b1;
    @(posedge clk);
    sb_q.delete();
    mcount = 0;
    last_d = '0;
    m_ovf = 0;
    m_unf = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.valid_i = 1'b0;
    bus.read_i  = 1'b0;
    chk({tag, ".valid_o"}, 32'(bus.valid_o), 32'd0);
    chk({tag, ".data_o"},  bus.data_o, 32'd0);
    chk_status(tag);
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.read_i  = 1'b0;
    bus.data_i  = '0;
    @(negedge clk);
    do_reset("reset");

    // single transfer
    step("single_push", 1, 32'd1, 0);
    step("single_pop",  0, '0,    1);
    step("single_idle", 0, '0,    0);

    // burst of 10 then a held read
    for (int i = 0; i < 10; i++) step("burst_push", 1, 32'(100 + i), 0);
    for (int i = 0; i < 10; i++) step("burst_pop",  0, '0, 1);
    step("burst_idle", 0, '0, 0);

    // fill, overflow attempt, full pass-through, drain
    for (int i = 0; i < LEN; i++) step("fill_push", 1, 32'(200 + i), 0);
    step("overflow_push", 1, 32'd999, 0);
    step("passthru",      1, 32'd500, 1);
    for (int i = 0; i < LEN; i++) step("drain_pop", 0, '0, 1);
    step("drain_idle", 0, '0, 0);

    // reads while empty, then simultaneous read/write while empty
    for (int i = 0; i < 3; i++) step("empty_read", 0, '0, 1);
    step("empty_rdwr", 1, 32'd42, 1);
    step("empty_rdwr_pop", 0, '0, 1);

    // streaming across pointer wrap
    for (int i = 0; i < 40; i++) step("stream", 1, 32'(1000 + i), 1);
    step("stream_tail", 0, '0, 1);

    // reset mid-operation
    for (int i = 0; i < 5; i++) step("mid_push", 1, 32'(300 + i), 0);
    do_reset("mid_reset");
    step("post_push", 1, 32'd7, 0);
    step("post_pop",  0, '0,    1);
    step("post_idle", 0, '0,    0);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/flo_fifo.md
Name: flo_fifo

Overview:
Synchronous single-clock FIFO used in the flocra datapath to buffer words between a bursty producer and a consumer that reads in bursts. Writes are qualified by valid_i and reads are pop requests on read_i. Popped data appears on a registered output with a one-cycle valid strobe. Occupancy, empty and full status are exported for flow control.

Parameters:
LENGTH, 32, number of storage entries; power of two, >= 2
WIDTH, 32, data word width in bits

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
data_i  input  WIDTH  write data
valid_i  input  1  write request; data_i is sampled at the rising edge while high
read_i  input  1  pop request; level-sensitive, one pop per cycle while high
data_o  output  WIDTH  most recently popped word (registered)
valid_o  output  1  high for exactly the cycle after each successful pop
locs_o  output  $clog2(LENGTH)  occupied entries, modulo LENGTH
empty_o  output  1  high when the FIFO holds 0 entries
full_o  output  1  high when the FIFO holds LENGTH entries

Behaviour:
- Internal state: wr_ptr and rd_ptr, each $clog2(LENGTH) bits, wrapping naturally at LENGTH; count register, $clog2(LENGTH)+1 bits.
- Storage array is not reset.
- Reset (rst=1 at an edge): wr_ptr=rd_ptr=0, count=0, data_o=0, valid_o=0.
  - Status after reset: empty_o=1, full_o=0, locs_o=0.
  - Any write or read in the same cycle as reset is discarded.
- Flags are derived combinationally from the count register, so they reflect the state after the last edge:
  - empty_o = (count==0)
  - full_o = (count==LENGTH)
  - locs_o = count[$clog2(LENGTH)-1:0]; reads 0 when full, full_o disambiguates.
- Pop: do_rd = read_i && !empty_o. On do_rd:
  - data_o <= mem[rd_ptr], valid_o <= 1, rd_ptr advances by 1.
  - Latency: data is valid on the cycle following the edge that sampled read_i.
- No pop: valid_o <= 0 and data_o holds its previous value. A read while empty is ignored, with no pointer change and no error.
- Push: do_wr = valid_i && (!full_o || read_i). On do_wr, mem[wr_ptr] <= data_i and wr_ptr advances by 1.
  - Write while full without a simultaneous read is silently dropped.
  - Write while full with read_i=1: the pop and the push both occur and count is unchanged.
- Simultaneous read and write when empty: the read is ignored (empty) and the write is stored; count becomes 1. The new word is not bypassed to data_o.
- Count update:
  - do_wr only: +1
  - do_rd only: -1
  - both, or neither: unchanged
- Continuous streaming: valid_i held high with read_i held high sustains one push and one pop per cycle.
- Ordering is strictly first-in first-out across pointer wrap-around.

Optional Feature:
FLOFIFO_ERR_FLAGS_EN — when defined, adds two outputs:
- overflow_o (1 bit): set when valid_i=1 at an edge where the write is dropped.
- underflow_o (1 bit): set when read_i=1 at an edge where empty_o=1.
- Both flags are sticky until rst and reset to 0.
When undefined, these ports and their logic do not exist; the dropped-write and empty-read behaviour is otherwise identical.

Test Plan:
- Single transfer: rst, then push 1 for one cycle → locs_o=1, empty_o=0. One-cycle read_i → next cycle data_o=1, valid_o=1 for one cycle; then empty_o=1, locs_o=0.
- Burst: push 100..109 on consecutive cycles → locs_o=10. Hold read_i for 10 cycles → data_o=100..109 in order on 10 consecutive valid_o cycles; then empty_o=1.
- Fill and overflow: push 200..231 (32 words) → full_o=1, locs_o=0. Push 999 → dropped (overflow_o=1 if FLOFIFO_ERR_FLAGS_EN). Drain → 200..231 in order, 999 never appears.
- Full-boundary pass-through: while full, valid_i=1 and read_i=1 with data 500 → pops the head word, full_o stays 1; after draining, 500 is the last word out.
- Empty read: read_i=1 while empty for 3 cycles → valid_o stays 0, data_o unchanged, locs_o=0 (underflow_o=1 if the macro is defined).
- Reset mid-operation: 5 words stored, assert rst for one cycle → empty_o=1, locs_o=0, valid_o=0. Subsequent push 7 and pop → data_o=7.
